cache_write_buffer: RTL and testbench
=====================================

# cache_write_buffer

Store-side companion to the cache read-data select path. It accepts CPU store requests (address, word, byte enables) into a small FIFO and drains them one at a time to the memory interface under a req/ack handshake. A comparator flags any pending store to a word address the load path is reading, so the pipeline can stall that load.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `AW`, 32: byte-address width; `RegBus` (`port_define.sv`) sets data width, 32 bits.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_req` in 1: CPU store request.
- `wr_addr` in AW: byte address; bits [1:0] ignored and stored as 0.
- `wr_data` in `RegBus`: store word.
- `wr_be` in 4: byte enables; all-zero requests are accepted and dropped.
- `wr_full` out 1: FIFO full; a `wr_req` in this cycle is not accepted.
- `rd_addr` in AW: load address for hazard check.
- `rd_conflict` out 1: combinational; a valid entry matches `rd_addr[AW-1:2]`.
- `mem_req` out 1: head entry presented to memory.
- `mem_addr`, `mem_data`, `mem_be` out AW / `RegBus` / 4: head entry fields.
- `mem_ack` in 1: memory accepted the presented entry.
- `empty` out 1: no valid entries and no transfer outstanding.

## Operation
- Storage: circular array of {addr, data, be}, write pointer, read pointer, count of width clog2(DEPTH)+1.
- Push happens when `wr_req && !wr_full && wr_be != 0`. The entry is written at the write pointer, and the pointer increments modulo DEPTH.
- Drain FSM:
  - IDLE: if count > 0, latch the head entry into output registers, assert `mem_req`, and go to BUSY.
  - BUSY: hold `mem_req` and all `mem_*` fields stable until `mem_ack`.
  - On `mem_ack` in BUSY, pop: the read pointer increments and count decrements.
    - If count after the pop is > 0, load the next head the same cycle and stay in BUSY, giving back-to-back transfers.
    - Otherwise go to IDLE and deassert `mem_req`.
- An entry stays counted, and visible to `rd_conflict`, until its `mem_ack`.
- `mem_ack` in IDLE is ignored.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- When full, a push is refused even if a pop occurs the same cycle. `wr_full` depends only on the registered count.
- Order: memory sees stores strictly in acceptance order. No merging and no reordering.
- `rd_conflict` compares the word address against every valid entry, including the head in flight. It does not depend on `wr_req` in the same cycle.

## Timing
- Reset values: count 0, pointers 0, FSM IDLE, `mem_req` 0, `mem_addr`/`mem_data`/`mem_be` 0, `wr_full` 0, `empty` 1.
- Reset asserted mid-transfer discards all entries immediately. Memory must tolerate `mem_req` dropping without an ack.
- Latency, empty buffer: push in cycle N, `mem_req` high in cycle N+1, earliest pop at the N+1 edge if `mem_ack` is high in N+1.
- Throughput: one store per cycle when `mem_ack` is held high.
- `wr_full` asserts the cycle after the DEPTH-th accepted push and deasserts the cycle after the next pop.
- `empty` equals (count == 0) and is registered-derived.

## Structure
- `cache_pkg`: `wb_entry_t` struct {addr, data, be} and the `WB_IDLE`/`WB_BUSY` FSM enum; the hazard check and `cache_read_mux` both import it.
- The FIFO is not a separate sub-module; one small sub-module `wb_addr_match` (per-entry word-address comparator with valid mask, OR-reduced) is natural and reused for `rd_conflict`.

## Test plan
- Single store: push addr 0x1003, data 0xDEADBEEF, be 0xF, `mem_ack` high on the first `mem_req` cycle. Expect `mem_req` one cycle after the push with `mem_addr` 0x1000, then `empty` back to 1.
- Fill: 4 pushes with `mem_ack` low. Expect `wr_full` 1; a 5th push (data 0x55) is never seen on memory. Release ack: stores appear in order 1..4, each held stable until its ack.
- Concurrent: keep count at 2 while pushing and acking every cycle for 20 cycles. Expect count to stay constant and all 20 stores to appear in order.
- Hazard: pending store at 0x2000. `rd_addr` 0x2002 gives `rd_conflict` 1; `rd_addr` 0x2004 gives 0. After ack, 0x2002 gives 0.
- Zero-enable push (be 0): not accepted, `empty` stays 1, no `mem_req`.
- Reset mid-BUSY with 3 entries: after `rst_n` low, `mem_req` 0, `empty` 1, `wr_full` 0, no stale store issued after release.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types for the cache store path.
//   REG_BUS    - data word width of the register/memory bus
//   WB_AW      - widest byte address a write-buffer entry can hold
//   wb_entry_t - one buffered store {addr, data, be}
//   wb_state_e - drain FSM states (WB_IDLE / WB_BUSY)
package cache_pkg;

  localparam int REG_BUS = 32;
  localparam int WB_AW   = 32;

  typedef struct packed {
    logic [WB_AW-1:0]   addr;
    logic [REG_BUS-1:0] data;
    logic [3:0]         be;
  } wb_entry_t;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_BUSY = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_addr_match.sv
// wb_addr_match: per-entry word-address comparator with a valid mask,
// OR-reduced into a single hit.
//   entry_waddr - DEPTH packed word addresses (entry i at [i*WAW +: WAW])
//   entry_vld   - one valid bit per entry
//   probe_waddr - word address to look up
//   hit         - some valid entry holds probe_waddr
module wb_addr_match #(
  parameter int DEPTH = 4,
  parameter int WAW   = 30
) (
  input  logic [DEPTH*WAW-1:0] entry_waddr,
  input  logic [DEPTH-1:0]     entry_vld,
  input  logic [WAW-1:0]       probe_waddr,
  output logic                 hit
);

  logic [DEPTH-1:0] hit_vec;

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit_vec[i] = entry_vld[i] && (entry_waddr[i*WAW +: WAW] == probe_waddr);
    end
  end

  assign hit = |hit_vec;

endmodule

// File: rtl/cache_write_buffer.sv
// cache_write_buffer: FIFO of CPU stores drained one at a time to memory
// under a req/ack handshake, with a load-address hazard comparator.
//   clk, rst_n                  - clock, async active-low reset
//   wr_req/wr_addr/wr_data/wr_be - CPU store request (be == 0 is dropped)
//   wr_full                     - buffer full, request refused this cycle
//   rd_addr, rd_conflict        - load address; a pending store hits its word
//   mem_req/mem_addr/mem_data/mem_be, mem_ack - memory-side handshake
//   empty                       - nothing buffered or in flight
module cache_write_buffer
  import cache_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_req,
  input  logic [AW-1:0]      wr_addr,
  input  logic [REG_BUS-1:0] wr_data,
  input  logic [3:0]         wr_be,
  output logic               wr_full,
  input  logic [AW-1:0]      rd_addr,
  output logic               rd_conflict,
  output logic               mem_req,
  output logic [AW-1:0]      mem_addr,
  output logic [REG_BUS-1:0] mem_data,
  output logic [3:0]         mem_be,
  input  logic               mem_ack,
  output logic               empty
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int WAW = AW - 2;

  wb_entry_t           fifo_mem [DEPTH];
  wb_entry_t           in_entry;
  wb_entry_t           load_entry;
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       rd_ptr_nxt1;
  logic [CW-1:0]       count;
  wb_state_e           state;
  wb_state_e           state_nxt;
  logic                push;
  logic                pop;
  logic                load_en;
  logic [DEPTH*WAW-1:0] entry_waddr;
  logic [DEPTH-1:0]    entry_vld;
  logic                unused_lsbs;

  // Byte-offset bits never take part in a word compare.
  assign unused_lsbs = ^{wr_addr[1:0], rd_addr[1:0]};

  always_comb begin
    in_entry      = '0;
    in_entry.addr = WB_AW'({wr_addr[AW-1:2], 2'b00});
    in_entry.data = wr_data;
    in_entry.be   = wr_be;
  end

  assign wr_full     = (count == CW'(DEPTH));
  assign empty       = (count == '0);
  assign mem_req     = (state == WB_BUSY);
  assign push        = wr_req && !wr_full && (wr_be != 4'b0000);
  assign pop         = (state == WB_BUSY) && mem_ack;
  assign rd_ptr_nxt1 = rd_ptr + 1'b1;

  // Drain FSM. When no older entry is waiting, the incoming store is loaded
  // straight into the output registers so an empty buffer issues one cycle
  // after the push and a sole in-flight entry can be followed back-to-back.
  always_comb begin
    state_nxt  = state;
    load_en    = 1'b0;
    load_entry = fifo_mem[rd_ptr];
    case (state)
      WB_IDLE: begin
        if (count != '0) begin
          load_en    = 1'b1;
          load_entry = fifo_mem[rd_ptr];
          state_nxt  = WB_BUSY;
        end else if (push) begin
          load_en    = 1'b1;
          load_entry = in_entry;
          state_nxt  = WB_BUSY;
        end
      end
      WB_BUSY: begin
        if (mem_ack) begin
          if (count > CW'(1)) begin
            load_en    = 1'b1;
            load_entry = fifo_mem[rd_ptr_nxt1];
          end else if (push) begin
            load_en    = 1'b1;
            load_entry = in_entry;
          end else begin
            state_nxt  = WB_IDLE;
          end
        end
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= WB_IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mem_addr <= '0;
      mem_data <= '0;
      mem_be   <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr_nxt1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (load_en) begin
        mem_addr <= load_entry.addr[AW-1:0];
        mem_data <= load_entry.data;
        mem_be   <= load_entry.be;
      end
    end
  end

  // Storage carries no reset; validity comes from count/rd_ptr.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= in_entry;
  end

  // Entry i is valid when its distance from the head is below count; the
  // head stays valid while in flight because it is only popped on ack.
  always_comb begin
    entry_vld   = '0;
    entry_waddr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] offs;
      offs = PW'(i) - rd_ptr;
      entry_vld[i] = ({1'b0, offs} < count);
      entry_waddr[i*WAW +: WAW] = fifo_mem[i].addr[AW-1:2];
    end
  end

  wb_addr_match #(
    .DEPTH (DEPTH),
    .WAW   (WAW)
  ) u_addr_match (
    .entry_waddr (entry_waddr),
    .entry_vld   (entry_vld),
    .probe_waddr (rd_addr[AW-1:2]),
    .hit         (rd_conflict)
  );

endmodule

// File: tb/tb_cache_write_buffer.sv
// tb_cache_write_buffer: directed self-checking bench for cache_write_buffer.
module tb_cache_write_buffer;

  logic        clk;
  logic        rst_n;
  logic        wr_req;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic        wr_full;
  logic [31:0] rd_addr;
  logic        rd_conflict;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        empty;

  int n_checks;
  int n_errors;

  logic [31:0] exp_q [$];

  cache_write_buffer #(
    .DEPTH (4),
    .AW    (32)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_req      (wr_req),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_be       (wr_be),
    .wr_full     (wr_full),
    .rd_addr     (rd_addr),
    .rd_conflict (rd_conflict),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_be      (mem_be),
    .mem_ack     (mem_ack),
    .empty       (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_req  = 1'b1;
    wr_addr = a;
    wr_data = d;
    wr_be   = be;
    tick();
    wr_req  = 1'b0;
    wr_be   = 4'h0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    wr_req   = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    wr_be    = '0;
    rd_addr  = '0;
    mem_ack  = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_mem_req", mem_req, 0);
    check("rst_empty", empty, 1);
    check("rst_wr_full", wr_full, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_data", mem_data, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_conflict", rd_conflict, 0);
    rst_n = 1'b1;
    tick();

    // Single store, one-cycle latency, ack on first req cycle
    push(32'h0000_1003, 32'hDEAD_BEEF, 4'hF);
    check("single_req", mem_req, 1);
    check("single_addr", mem_addr, 32'h0000_1000);
    check("single_data", mem_data, 32'hDEAD_BEEF);
    check("single_be", mem_be, 4'hF);
    check("single_not_empty", empty, 0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("single_req_drop", mem_req, 0);
    check("single_empty", empty, 1);

    // Zero byte-enable store is dropped
    push(32'h0000_3000, 32'h1234_5678, 4'h0);
    check("zbe_empty", empty, 1);
    check("zbe_req", mem_req, 0);
    tick();
    check("zbe_req_later", mem_req, 0);

    // Ack in IDLE is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("idle_ack_empty", empty, 1);

    // Fill to DEPTH with ack low, refuse a fifth
    for (int i = 1; i <= 4; i++) push(32'h100 * i, i, 4'h3);
    check("fill_full", wr_full, 1);
    check("fill_req", mem_req, 1);
    check("fill_head", mem_data, 1);
    push(32'h0000_0500, 32'h55, 4'hF);
    check("fill_full_hold", wr_full, 1);
    check("fill_head_stable", mem_data, 1);
    check("fill_addr_stable", mem_addr, 32'h100);
    mem_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("drain_data%0d", i), mem_data, i);
      check($sformatf("drain_addr%0d", i), mem_addr, 32'h100 * i);
      check($sformatf("drain_req%0d", i), mem_req, 1);
      tick();
      if (i == 1) check("full_release", wr_full, 0);
    end
    mem_ack = 1'b0;
    check("drain_done_req", mem_req, 0);
    check("drain_done_empty", empty, 1);
    tick();
    check("no_fifth_store", mem_req, 0);

    // Concurrent push/ack with two entries held
    exp_q.delete();
    push(32'h0000_4000, 32'hA0, 4'hF);
    exp_q.push_back(32'hA0);
    push(32'h0000_4004, 32'hA1, 4'hF);
    exp_q.push_back(32'hA1);
    for (int k = 0; k < 20; k++) begin
      wr_req  = 1'b1;
      wr_addr = 32'h0000_4100 + 32'(4 * k);
      wr_data = 32'hB0 + 32'(k);
      wr_be   = 4'hF;
      mem_ack = 1'b1;
      check($sformatf("conc_data%0d", k), mem_data, exp_q[0]);
      check($sformatf("conc_req%0d", k), mem_req, 1);
      check($sformatf("conc_full%0d", k), wr_full, 0);
      tick();
      void'(exp_q.pop_front());
      exp_q.push_back(32'hB0 + 32'(k));
    end
    wr_req = 1'b0;
    wr_be  = 4'h0;
    check("conc_tail0", mem_data, exp_q[0]);
    tick();
    check("conc_tail1", mem_data, exp_q[1]);
    check("conc_not_empty", empty, 0);
    tick();
    mem_ack = 1'b0;
    check("conc_empty", empty, 1);
    check("conc_req_drop", mem_req, 0);

    // Hazard compare against head and non-head entries
    push(32'h0000_2000, 32'h77, 4'hF);
    push(32'h0000_2010, 32'h78, 4'hF);
    rd_addr = 32'h0000_2002;
    #1;
    check("haz_head_hit", rd_conflict, 1);
    rd_addr = 32'h0000_2004;
    #1;
    check("haz_next_word", rd_conflict, 0);
    rd_addr = 32'h0000_2013;
    #1;
    check("haz_second_hit", rd_conflict, 1);
    wr_req  = 1'b1;
    wr_addr = 32'h0000_2020;
    wr_be   = 4'h0;
    rd_addr = 32'h0000_2020;
    #1;
    check("haz_ignores_wr", rd_conflict, 0);
    wr_req  = 1'b0;
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    rd_addr = 32'h0000_2002;
    #1;
    check("haz_after_ack", rd_conflict, 0);
    rd_addr = 32'h0000_2010;
    #1;
    check("haz_remaining", rd_conflict, 1);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    #1;
    check("haz_all_acked", rd_conflict, 0);
    check("haz_empty", empty, 1);
    rd_addr = '0;

    // Reset while BUSY with three entries
    for (int i = 0; i < 3; i++) push(32'h0000_5000 + 32'(4 * i), 32'hC0 + 32'(i), 4'hF);
    check("mid_req", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_full", wr_full, 0);
    check("mid_rst_addr", mem_addr, 0);
    tick();
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_req%0d", i), mem_req, 0);
      check($sformatf("post_rst_empty%0d", i), empty, 1);
    end
    mem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
